// File: rtl/dsp_pkg.sv
// Shared DSP types and constants; this slice adds the 32-point FFT framer items.
package dsp_pkg;
  localparam int FFT32_FRAME_LEN   = 32;
  localparam int FFT32_INDEX_WIDTH = 5;
  localparam int FFT32_TAG_WIDTH   = 8;

  typedef struct packed {
    logic                         valid;
    logic                         last;
    logic                         reverse;
    logic [FFT32_INDEX_WIDTH-1:0] data_index;
    logic [FFT32_TAG_WIDTH-1:0]   tag;
  } fft32_control_t;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } fft32_bank_state_t;

  function automatic logic [FFT32_INDEX_WIDTH-1:0] fft32_bitrev(
    input logic [FFT32_INDEX_WIDTH-1:0] a);
    logic [FFT32_INDEX_WIDTH-1:0] r;
    for (int b = 0; b < FFT32_INDEX_WIDTH; b++) r[b] = a[FFT32_INDEX_WIDTH-1-b];
    return r;
  endfunction
endpackage

// File: rtl/fft_32_framer_bank.sv
// Two-bank sample store for the FFT32 framer: simple dual-port RAM, address {bank, idx}, registered read.
module fft_32_framer_bank
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                            Clk,
  input  logic                            wr_en,
  input  logic [FFT32_INDEX_WIDTH:0]      wr_addr,
  input  logic [2*DATA_WIDTH-1:0]         wr_data,
  input  logic                            rd_en,
  input  logic [FFT32_INDEX_WIDTH:0]      rd_addr,
  output logic [2*DATA_WIDTH-1:0]         rd_data
);
  logic [2*DATA_WIDTH-1:0] mem [2*FFT32_FRAME_LEN];

  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fft_32_input_framer.sv
// Groups an unframed I/Q stream into 32-sample frames and replays each as an FFT32 control stream.
// FFT32_FRAMER_BITREV_EN: replay frames in bit-reversed address order.
module fft_32_input_framer
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Input_valid,
  input  logic signed [DATA_WIDTH-1:0] Input_i,
  input  logic signed [DATA_WIDTH-1:0] Input_q,
  input  logic                         Input_reverse,
  output fft32_control_t               Output_control,
  output logic signed [DATA_WIDTH-1:0] Output_i,
  output logic signed [DATA_WIDTH-1:0] Output_q,
  output logic                         Error_overflow
);
  localparam logic [FFT32_INDEX_WIDTH-1:0] IDX_LAST = FFT32_INDEX_WIDTH'(FFT32_FRAME_LEN - 1);

  typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

  fft32_bank_state_t            bank_st  [2];
  logic                         bank_rev [2];
  logic [FFT32_TAG_WIDTH-1:0]   bank_tag [2];
  logic [FFT32_INDEX_WIDTH-1:0] wr_idx, rd_idx, rd_addr;
  logic [FFT32_TAG_WIDTH-1:0]   tag_cnt;
  logic                         wr_bank, rd_bank, drop;
  rd_state_t                    rd_st;

  logic start_ok, wr_drop, wr_en;
  logic rd_start, rd_en, rd_end, rd_chain;

  // The drop decision for a frame is made at its first sample and held in drop.
  assign start_ok = bank_st[wr_bank] == BANK_EMPTY;
  assign wr_drop  = (wr_idx == '0) ? !start_ok : drop;
  assign wr_en    = Input_valid && !wr_drop;

  // Reads alternate banks, so rd_bank is always the oldest candidate; idle rd_idx is 0.
  assign rd_start = rd_st == RD_IDLE && bank_st[rd_bank] == BANK_FULL;
  assign rd_en    = rd_start || rd_st == RD_RUN;
  assign rd_end   = rd_st == RD_RUN && rd_idx == IDX_LAST;
  assign rd_chain = rd_end && bank_st[~rd_bank] == BANK_FULL;

`ifdef FFT32_FRAMER_BITREV_EN
  assign rd_addr = fft32_bitrev(rd_idx);
`else
  assign rd_addr = rd_idx;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int b = 0; b < 2; b++) begin
        bank_st[b]  <= BANK_EMPTY;
        bank_rev[b] <= 1'b0;
        bank_tag[b] <= '0;
      end
      wr_idx         <= '0;
      rd_idx         <= '0;
      tag_cnt        <= '0;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      drop           <= 1'b0;
      rd_st          <= RD_IDLE;
      Error_overflow <= 1'b0;
    end else begin
      if (Input_valid) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_idx == '0) begin
          drop <= !start_ok;
          if (start_ok) begin
            bank_st[wr_bank]  <= BANK_FILLING;
            bank_rev[wr_bank] <= Input_reverse;
            bank_tag[wr_bank] <= tag_cnt;
            tag_cnt           <= tag_cnt + 1'b1;
          end
        end else if (wr_idx == IDX_LAST && !drop) begin
          bank_st[wr_bank] <= BANK_FULL;
          wr_bank          <= ~wr_bank;
        end
      end
      Error_overflow <= Input_valid && wr_idx == '0 && !start_ok;

      // Write and read sides never touch the same bank in one cycle (disjoint states).
      if (rd_en) rd_idx <= rd_idx + 1'b1;
      if (rd_start) begin
        bank_st[rd_bank] <= BANK_READING;
        rd_st            <= RD_RUN;
      end
      if (rd_end) begin
        bank_st[rd_bank] <= BANK_EMPTY;
        rd_bank          <= ~rd_bank;
        if (rd_chain) bank_st[~rd_bank] <= BANK_READING;
        else          rd_st             <= RD_IDLE;
      end
    end
  end

  logic [2*DATA_WIDTH-1:0]      rd_data;
  logic                         s1_vld, s1_last, s1_rev;
  logic [FFT32_INDEX_WIDTH-1:0] s1_idx;
  logic [FFT32_TAG_WIDTH-1:0]   s1_tag;

  fft_32_framer_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank (
    .Clk     (Clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data ({Input_i, Input_q}),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_addr}),
    .rd_data (rd_data)
  );

  // Side-band travels alongside the RAM read register, then both land in the output register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_rev  <= 1'b0;
      s1_idx  <= '0;
      s1_tag  <= '0;
    end else begin
      s1_vld  <= rd_en;
      s1_last <= rd_idx == IDX_LAST;
      s1_rev  <= bank_rev[rd_bank];
      s1_idx  <= rd_addr;
      s1_tag  <= bank_tag[rd_bank];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst || !s1_vld) begin
      Output_control <= '0;
      Output_i       <= '0;
      Output_q       <= '0;
    end else begin
      Output_control.valid      <= 1'b1;
      Output_control.last       <= s1_last;
      Output_control.reverse    <= s1_rev;
      Output_control.data_index <= s1_idx;
      Output_control.tag        <= s1_tag;
      Output_i                  <= rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
      Output_q                  <= rd_data[DATA_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_fft_32_input_framer.sv
// Directed bench for fft_32_input_framer: ramps, gaps, reverse flag, resets and tag wrap.
module tb_fft_32_input_framer;
  import dsp_pkg::*;
  localparam int DW = 16;

  logic                 Clk = 1'b0;
  logic                 Rst;
  logic                 Input_valid, Input_reverse;
  logic signed [DW-1:0] Input_i, Input_q, Output_i, Output_q;
  fft32_control_t       Output_control;
  logic                 Error_overflow;

  fft_32_input_framer #(.DATA_WIDTH(DW)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Input_valid    (Input_valid),
    .Input_i        (Input_i),
    .Input_q        (Input_q),
    .Input_reverse  (Input_reverse),
    .Output_control (Output_control),
    .Output_i       (Output_i),
    .Output_q       (Output_q),
    .Error_overflow (Error_overflow)
  );

  always #5 Clk = ~Clk;

  int          cyc = 0;
  int          acc_edge = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          ovf_cnt = 0;
  int          hold_bad = 0;
  bit          mon_en = 1'b0;
  logic [47:0] mon_d[$];
  int          mon_e[$];

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (mon_en) begin
      if (Output_control.valid === 1'b1) begin
        mon_d.push_back({Output_i, Output_q, Output_control});
        mon_e.push_back(cyc);
      end else if ({Output_i, Output_q, Output_control} !== 48'h0) begin
        hold_bad++;
      end
      if (Error_overflow !== 1'b0) ovf_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input int j);
    int r;
    r = j;
`ifdef FFT32_FRAMER_BITREV_EN
    r = 0;
    for (int b = 0; b < 5; b++) if ((j & (1 << b)) != 0) r = r | (1 << (4 - b));
`endif
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic send(input int i, input int q, input bit rev);
    Input_valid = 1'b1; Input_i = DW'(i); Input_q = DW'(q); Input_reverse = rev;
    @(posedge Clk); #1;
    Input_valid = 1'b0;
    acc_edge = cyc;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1;
  endtask

  task automatic clear_mon();
    mon_d.delete();
    mon_e.delete();
  endtask

  // Waits (bounded) for n outputs, then confirms nothing extra trails them.
  task automatic wait_out(input string tag, input int n);
    int t;
    t = 0;
    while (mon_d.size() < n && t < 300) begin idle(1); t++; end
    idle(5);
    chk(tag, 64'(mon_d.size()), 64'(n));
  endtask

  task automatic check_stream(input string tag, input int nfr, input bit ramp, input int cval,
                              input bit rev0, input bit rev1);
    int f, j, a, v;
    fft32_control_t c;
    logic [47:0] exp;
    for (int k = 0; k < nfr * 32; k++) begin
      f = k / 32; j = k % 32; a = idx_of(j);
      v = ramp ? f * 32 + a : cval;
      c.valid = 1'b1; c.last = (j == 31); c.reverse = (f == 0) ? rev0 : rev1;
      c.data_index = 5'(a); c.tag = 8'(f);
      exp = {DW'(v), DW'(-v), c};
      chk({tag, "_data"}, 64'(mon_d[k]), 64'(exp));
      if (j > 0) chk({tag, "_gap"}, 64'(mon_e[k]), 64'(mon_e[k-1] + 1));
    end
  endtask

  initial begin
    int e31;
    bit any_last;
    bit rev;
    Rst = 1'b0; Input_valid = 1'b0; Input_i = '0; Input_q = '0; Input_reverse = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    mon_en = 1'b1;

    chk("rst_ctl", 64'(Output_control), 64'h0);
    chk("rst_i", 64'(Output_i), 64'h0);
    chk("rst_q", 64'(Output_q), 64'h0);
    chk("rst_ovf", 64'(Error_overflow), 64'h0);

    // Back-to-back ramp: two frames, fixed latency, no gap between frames.
    e31 = 0;
    for (int k = 0; k < 64; k++) begin
      send(k, -k, 1'b0);
      if (k == 31) e31 = acc_edge;
    end
    wait_out("ramp_cnt", 64);
    check_stream("ramp", 2, 1'b1, 0, 1'b0, 1'b0);
    chk("ramp_lat", 64'(mon_e[0]), 64'(e31 + 2));
    chk("ramp_b2b", 64'(mon_e[32]), 64'(mon_e[31] + 1));
    clear_mon();

    // Same ramp with random gaps between samples.
    do_reset();
    for (int k = 0; k < 64; k++) begin
      send(k, -k, 1'b0);
      idle($urandom_range(5, 0));
    end
    wait_out("gap_cnt", 64);
    check_stream("gapramp", 2, 1'b1, 0, 1'b0, 1'b0);
    clear_mon();

    // Reverse flag latched on each frame's first sample only.
    do_reset();
    for (int k = 0; k < 64; k++) begin
      if (k == 0) rev = 1'b1;
      else if (k == 32) rev = 1'b0;
      else rev = k[0];
      send(k, -k, rev);
    end
    wait_out("rev_cnt", 64);
    check_stream("rev", 2, 1'b1, 0, 1'b1, 1'b0);
    clear_mon();

    // Reset mid-read discards the rest of the frame, with no trailing last.
    do_reset();
    for (int k = 0; k < 32; k++) send(k, -k, 1'b0);
    idle(10);
    do_reset();
    chk("rst_rd_valid", 64'(Output_control.valid), 64'h0);
    idle(3);
    chk("partial_cnt", 64'(mon_d.size()), 64'd9);
    any_last = 1'b0;
    foreach (mon_d[k]) if (mon_d[k][14] === 1'b1) any_last = 1'b1;
    chk("partial_last", 64'(any_last), 64'h0);
    clear_mon();

    // Partial write then reset, then a full frame of 7s.
    for (int k = 0; k < 20; k++) send(100 + k, 0, 1'b0);
    do_reset();
    for (int k = 0; k < 32; k++) send(7, -7, 1'b0);
    wait_out("sevens_cnt", 32);
    check_stream("sevens", 1, 1'b0, 7, 1'b0, 1'b0);
    clear_mon();

    // 257 frames: tag wraps 255 -> 0 on the last frame.
    do_reset();
    for (int k = 0; k < 257 * 32; k++) send(k, -k, 1'b0);
    wait_out("wrap_cnt", 257 * 32);
    check_stream("wrap", 257, 1'b1, 0, 1'b0, 1'b0);
    chk("wrap_tag256", 64'(mon_d[256 * 32][7:0]), 64'h0);
    clear_mon();

    chk("ovf_never", 64'(ovf_cnt), 64'h0);
    chk("idle_hold", 64'(hold_bad), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
